debug_ocimem_arbiter: RTL and testbench



---
 rtl/debug_ocimem_arbiter_pkg.sv | 11 +
 rtl/debug_ocimem_jtag_cmd.sv | 55 +++++
 rtl/debug_ocimem_arbiter.sv | 82 ++++++++
 tb/tb_debug_ocimem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_ocimem_arbiter_pkg.sv
// debug_ocimem_arbiter_pkg: shared states, JTAG command types and jdo field positions
package debug_ocimem_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, J_ACC, J_RDATA, C_ACC, C_RDATA} state_t;
  typedef enum logic [1:0] {LOAD, LOAD_RD, RD_INC, WR_INC} cmd_t;
  typedef enum logic {GRANT_JTAG, GRANT_CPU} grant_t;
  localparam int ADDR_MSB  = 33;
  localparam int ADDR_LSB  = 26;
  localparam int RD_FLAG   = 25;
  localparam int WDATA_MSB = 34;
  localparam int WDATA_LSB = 3;
endpackage

// File: rtl/debug_ocimem_jtag_cmd.sv
// debug_ocimem_jtag_cmd: JTAG strobe decode, one-entry pending command, auto-increment pointer, overrun flag
module debug_ocimem_jtag_cmd
  import debug_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  state_t            state,
  output logic              pend_valid,
  output cmd_t              pend_cmd,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] pend_wdata,
  output logic              monitor_error
);
  logic [ADDR_W-1:0] pointer, jdo_addr;
  logic strobe, accept, done, inc, unused_jdo;
  cmd_t cmd_in;
  assign strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // pending stays valid until the command completes, so it also covers an access in flight
  assign accept = strobe & ~pend_valid;
  assign jdo_addr = ADDR_W'(jdo[ADDR_MSB:ADDR_LSB]);
  assign cmd_in = take_action_ocimem_a ? (jdo[RD_FLAG] ? LOAD_RD : LOAD)
                : take_no_action_ocimem_a ? RD_INC : WR_INC;
  assign done = pend_valid & (pend_cmd == LOAD | state == J_RDATA | (state == J_ACC & pend_cmd == WR_INC));
  assign inc = state == J_ACC & (pend_cmd == RD_INC | pend_cmd == WR_INC);
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid    <= 1'b0;
      pend_cmd      <= LOAD;
      pend_addr     <= '0;
      pend_wdata    <= '0;
      pointer       <= '0;
      monitor_error <= 1'b0;
    end else begin
      if (accept) begin
        pend_valid <= 1'b1;
        pend_cmd   <= cmd_in;
        pend_addr  <= take_action_ocimem_a ? jdo_addr : pointer;
        pend_wdata <= DATA_W'(jdo[WDATA_MSB:WDATA_LSB]);
      end else if (done) begin
        pend_valid <= 1'b0;
      end
      if (accept & take_action_ocimem_a) pointer <= jdo_addr;
      else if (inc) pointer <= pointer + 1'b1;
      if (strobe & pend_valid) monitor_error <= 1'b1;
    end
  end
endmodule

// File: rtl/debug_ocimem_arbiter.sv
// debug_ocimem_arbiter: round-robin sharing of the OCI debug RAM between JTAG commands and the CPU slave
module debug_ocimem_arbiter
  import debug_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_t state, state_nx;
  grant_t last_grant;
  cmd_t pend_cmd;
  logic pend_valid, cpu_req, j_grant;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;
  debug_ocimem_jtag_cmd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmd (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .state                   (state),
    .pend_valid              (pend_valid),
    .pend_cmd                (pend_cmd),
    .pend_addr               (pend_addr),
    .pend_wdata              (pend_wdata),
    .monitor_error           (monitor_error)
  );
  assign cpu_req = cpu_read | cpu_write;
  // a bare address load completes inside the command block and never competes for the RAM
  assign j_grant = pend_valid & pend_cmd != LOAD & (~cpu_req | last_grant == GRANT_CPU);
  assign monitor_ready = ~pend_valid;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb
    state_nx = state == IDLE  ? (j_grant ? J_ACC : cpu_req ? C_ACC : IDLE)
             : state == J_ACC ? (pend_cmd != WR_INC ? J_RDATA : IDLE)
             : state == C_ACC ? (cpu_read & ~cpu_write ? C_RDATA : IDLE)
             : IDLE;
  always_comb begin
    ram_addr          = state == J_ACC ? pend_addr : state == C_ACC ? cpu_address : '0;
    ram_wdata         = state == J_ACC ? pend_wdata : state == C_ACC ? cpu_writedata : '0;
    ram_be            = state == J_ACC ? 4'hF : state == C_ACC ? cpu_byteenable : 4'h0;
    ram_we            = (state == J_ACC & pend_cmd == WR_INC) | (state == C_ACC & cpu_write);
    cpu_waitrequest   = cpu_req & state != C_ACC;
    cpu_readdata      = state == C_RDATA ? ram_rdata : '0;
    cpu_readdatavalid = state == C_RDATA;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_CPU;
      MonDReg    <= '0;
    end else begin
      last_grant <= state == J_ACC ? GRANT_JTAG : state == C_ACC ? GRANT_CPU : last_grant;
      if (state == J_RDATA) MonDReg <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// tb_debug_ocimem_arbiter: scenario tasks with queue scoreboards for JTAG and CPU read data
module tb_debug_ocimem_arbiter;
  localparam int K_LOAD = 0, K_RD = 1, K_WR = 2;
  logic clk = 1'b0, reset;
  logic [37:0] jdo;
  logic take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic monitor_ready, monitor_error;
  logic cpu_read, cpu_write, cpu_waitrequest, cpu_readdatavalid;
  logic [7:0] cpu_address;
  logic [31:0] cpu_writedata, cpu_readdata;
  logic [3:0] cpu_byteenable;
  logic [7:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0] ram_be;
  logic ram_we;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] mon_q[$], cpu_q[$], jd_q[$];
  logic [7:0] ja_q[$];
  logic [7:0] ptr;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  debug_ocimem_arbiter dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  initial for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | i;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we && ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  task automatic strobe(input int kind, input logic [7:0] addr, input logic rd, input logic [31:0] data);
    @(negedge clk);
    jdo = '0;
    if (kind == K_WR) jdo[34:3] = data;
    else begin
      jdo[33:26] = addr;
      jdo[25] = rd;
    end
    take_action_ocimem_a = kind == K_LOAD;
    take_no_action_ocimem_a = kind == K_RD;
    take_action_ocimem_b = kind == K_WR;
    @(negedge clk);
    {take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b} = 3'b000;
  endtask

  task automatic jtag_cmd(input int kind, input logic [7:0] addr, input logic rd,
                          input logic [31:0] data, input int exp_lat, input string name);
    logic [7:0] exp_addr, acc_addr;
    logic [31:0] acc_wdata, exp;
    logic acc_we, reads;
    int seen, lat;
    reads = kind == K_RD || (kind == K_LOAD && rd);
    if (kind == K_LOAD) ptr = addr;
    exp_addr = ptr;
    if (kind != K_LOAD) ptr = ptr + 8'd1;
    if (kind == K_WR) ref_mem[exp_addr] = data;
    if (reads) mon_q.push_back(ref_mem[exp_addr]);
    strobe(kind, addr, rd, data);
    seen = 0;
    lat = 1;
    while (!monitor_ready && lat < 20) begin
      if (ram_be != 4'h0) begin
        seen++;
        acc_addr = ram_addr;
        acc_wdata = ram_wdata;
        acc_we = ram_we;
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL %s_timeout: monitor_ready=%b required 1", name, monitor_ready); end
    if (exp_lat > 0) begin
      checks++;
      if (lat != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, exp_lat); end
    end
    if (kind == K_LOAD && !rd) begin
      checks++;
      if (seen != 0) begin errors++; $display("FAIL %s_no_access: saw %0d RAM accesses required 0", name, seen); end
    end else begin
      checks++;
      if (seen != 1 || acc_addr !== exp_addr || acc_we !== (kind == K_WR)) begin
        errors++;
        $display("FAIL %s_access: n=%0d addr=%h we=%b required n=1 addr=%h we=%b", name, seen, acc_addr, acc_we, exp_addr, kind == K_WR);
      end
      if (kind == K_WR) begin
        checks++;
        if (acc_wdata !== data) begin errors++; $display("FAIL %s_wdata: got %h required %h", name, acc_wdata, data); end
      end
    end
    if (reads) begin
      exp = mon_q.pop_front();
      checks++;
      if (MonDReg !== exp) begin errors++; $display("FAIL %s_mondreg: got %h required %h", name, MonDReg, exp); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ptr = 8'h00;
    @(negedge clk);
    checks++;
    if (MonDReg !== 32'h0 || monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_monitor: MonDReg=%h ready=%b error=%b required 0/1/0", MonDReg, monitor_ready, monitor_error);
    end
    checks++;
    if (cpu_readdatavalid !== 1'b0 || ram_we !== 1'b0 || cpu_waitrequest !== 1'b0 || ram_addr !== 8'h0) begin
      errors++;
      $display("FAIL reset_bus: valid=%b we=%b wait=%b addr=%h required all 0", cpu_readdatavalid, ram_we, cpu_waitrequest, ram_addr);
    end
  endtask

  task automatic test_load();
    jtag_cmd(K_LOAD, 8'h10, 1'b0, 32'h0, 2, "load");
  endtask

  task automatic test_writes();
    for (int i = 0; i < 3; i++) jtag_cmd(K_WR, 8'h0, 1'b0, 32'hA5A50001 + i, 3, "write");
    jtag_cmd(K_RD, 8'h0, 1'b0, 32'h0, 4, "rd_ptr13");
    jtag_cmd(K_LOAD, 8'h11, 1'b1, 32'h0, 4, "readback");
  endtask

  task automatic test_read_wrap();
    jtag_cmd(K_LOAD, 8'hFF, 1'b1, 32'h0, 4, "load_rd_ff");
    jtag_cmd(K_RD, 8'h0, 1'b0, 32'h0, 4, "rd_ff");
    jtag_cmd(K_RD, 8'h0, 1'b0, 32'h0, 4, "rd_00");
    jtag_cmd(K_RD, 8'h0, 1'b0, 32'h0, 4, "rd_wrap01");
  endtask

  task automatic test_cpu();
    logic [31:0] exp;
    @(negedge clk);
    cpu_write = 1'b1; cpu_address = 8'h50; cpu_writedata = 32'h12345678; cpu_byteenable = 4'b0011;
    ref_mem[8'h50] = {ref_mem[8'h50][31:16], 16'h5678};
    #1;
    checks++;
    if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL cpu_wr_wait_idle: got %b required 1", cpu_waitrequest); end
    @(negedge clk);
    checks++;
    if (cpu_waitrequest !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 8'h50 || ram_be !== 4'b0011 || ram_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL cpu_wr_acc: wait=%b we=%b addr=%h be=%h wdata=%h required 0/1/50/3/12345678", cpu_waitrequest, ram_we, ram_addr, ram_be, ram_wdata);
    end
    @(negedge clk);
    cpu_write = 1'b0; cpu_read = 1'b1; cpu_byteenable = 4'hF;
    cpu_q.push_back(ref_mem[8'h50]);
    @(negedge clk);
    checks++;
    if (cpu_waitrequest !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL cpu_rd_acc: wait=%b we=%b required 0/0", cpu_waitrequest, ram_we); end
    @(negedge clk);
    cpu_read = 1'b0;
    exp = cpu_q.pop_front();
    checks++;
    if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== exp) begin
      errors++;
      $display("FAIL cpu_rd_data: valid=%b data=%h required 1/%h", cpu_readdatavalid, cpu_readdata, exp);
    end
  endtask

  task automatic test_contention();
    int n_wr, n_j, cpu_since_j, j_at;
    logic done, drop, acc;
    logic [31:0] exp, d;
    n_wr = 0; n_j = 0; cpu_since_j = 0; j_at = -1; done = 1'b0; drop = 1'b0;
    @(negedge clk);
    cpu_address = 8'h40; cpu_byteenable = 4'hF; cpu_read = 1'b1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      take_action_ocimem_b = 1'b0;
      if (drop) cpu_read = 1'b0;
      acc = cpu_read && !cpu_waitrequest;
      if (acc) begin
        cpu_q.push_back(ref_mem[8'h40]);
        cpu_since_j++;
        if (n_j == 4) drop = 1'b1;
      end
      if (cpu_readdatavalid) begin
        exp = cpu_q.size() > 0 ? cpu_q.pop_front() : 32'hDEADBEEF;
        checks++;
        if (cpu_readdata !== exp) begin errors++; $display("FAIL cont_cpu_data: got %h required %h", cpu_readdata, exp); end
        if (j_at >= 0) begin
          checks++;
          if (cyc - j_at > 3) begin errors++; $display("FAIL cont_cpu_latency: %0d cycles after JTAG access required <=3", cyc - j_at); end
          j_at = -1;
        end
      end
      if (ram_we) begin
        checks++;
        if (ja_q.size() == 0 || ram_addr !== ja_q[0] || ram_wdata !== jd_q[0]) begin
          errors++;
          $display("FAIL cont_jtag_write: addr=%h data=%h unexpected", ram_addr, ram_wdata);
        end
        if (ja_q.size() > 0) begin void'(ja_q.pop_front()); void'(jd_q.pop_front()); end
        checks++;
        if (cpu_since_j == 0) begin errors++; $display("FAIL cont_alternate: got 0 CPU grants before JTAG access required >=1"); end
        cpu_since_j = 0;
        j_at = cyc;
        n_j++;
      end
      if (monitor_ready && n_wr < 4) begin
        d = 32'h5A5A0000 + n_wr;
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        ja_q.push_back(ptr);
        jd_q.push_back(d);
        ref_mem[ptr] = d;
        ptr = ptr + 8'd1;
        n_wr++;
      end
      done = n_j == 4 && !cpu_read && cpu_q.size() == 0 && j_at < 0;
    end
    cpu_read = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL cont_timeout: jtag_accesses=%0d required 4 with CPU drained", n_j); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_addr, a;
    logic [31:0] d;
    int n;
    exp_addr = ptr;
    @(negedge clk);
    jdo = '0; jdo[34:3] = 32'h0BAD0001; take_action_ocimem_b = 1'b1;
    @(negedge clk);
    jdo = '0; jdo[34:3] = 32'h0BAD0002;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    checks++;
    if (monitor_error !== 1'b1 || monitor_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovr_flag: error=%b ready=%b required 1/0", monitor_error, monitor_ready);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (ram_we) begin n++; a = ram_addr; d = ram_wdata; end
      @(negedge clk);
    end
    ref_mem[exp_addr] = 32'h0BAD0001;
    ptr = ptr + 8'd1;
    checks++;
    if (n != 1 || a !== exp_addr || d !== 32'h0BAD0001 || monitor_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovr_first: writes=%0d addr=%h data=%h ready=%b required 1/%h/0bad0001/1", n, a, d, monitor_ready, exp_addr);
    end
    jtag_cmd(K_RD, 8'h0, 1'b0, 32'h0, 4, "ovr_next_rd");
    jtag_cmd(K_LOAD, exp_addr, 1'b1, 32'h0, 4, "ovr_readback");
    checks++;
    if (monitor_error !== 1'b1) begin errors++; $display("FAIL ovr_sticky: error=%b required 1", monitor_error); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    cpu_address = 8'h40; cpu_read = 1'b1;
    jdo = '0; jdo[34:3] = 32'h77777777; take_action_ocimem_b = 1'b1;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    checks++;
    if (cpu_waitrequest !== 1'b0 || monitor_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_c_acc: wait=%b ready=%b required 0/0", cpu_waitrequest, monitor_ready);
    end
    reset = 1'b1; cpu_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ptr = 8'h00;
    checks++;
    if (cpu_readdatavalid !== 1'b0 || ram_we !== 1'b0 || ram_be !== 4'h0 || ram_addr !== 8'h0) begin
      errors++;
      $display("FAIL mid_bus: valid=%b we=%b be=%h addr=%h required all 0", cpu_readdatavalid, ram_we, ram_be, ram_addr);
    end
    checks++;
    if (MonDReg !== 32'h0 || monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin
      errors++;
      $display("FAIL mid_monitor: MonDReg=%h ready=%b error=%b required 0/1/0", MonDReg, monitor_ready, monitor_error);
    end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_readdatavalid || ram_we) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL mid_discard: saw %0d valid/write cycles required 0", n); end
    jtag_cmd(K_RD, 8'h0, 1'b0, 32'h0, 4, "mid_ptr_zero");
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    {take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b} = 3'b000;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_writedata = '0; cpu_byteenable = 4'hF;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE0000 | i;
    test_reset();
    test_load();
    test_writes();
    test_read_wrap();
    test_cpu();
    test_contention();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
